vector_core_mc: RTL and testbench
=================================

VECTOR_CORE_MC -- requirements
Module: vector_core_mc

Interface
REQ-001 The block SHALL use parameter LANES, default 8, meaning the number of vector lanes.
REQ-002 The block SHALL use parameter ELEM_W, default 8, meaning the bits per lane and the scalar width.
REQ-003 The block SHALL use parameter NREG, default 32, meaning the entries in each register file; it is a power of two ≤32.
REQ-004 The block SHALL use parameter ADDR_W, default 12, meaning the width of the data and instruction addresses.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-low.
REQ-007 The block SHALL have port imem_req, output, 1 bit: the instruction fetch request.
REQ-008 The block SHALL have port imem_addr, output, ADDR_W bits: the PC.
REQ-009 The block SHALL have port imem_ack, input, 1 bit: the fetch complete signal; imem_rdata is valid with it.
REQ-010 The block SHALL have port imem_rdata, input, 32 bits: the instruction word.
REQ-011 The block SHALL have port dmem_req, output, 1 bit: the data access request.
REQ-012 The block SHALL have port dmem_we, output, 1 bit: 1 for a store.
REQ-013 The block SHALL have port dmem_addr, output, ADDR_W bits: the data address.
REQ-014 The block SHALL have port dmem_wdata, output, LANES*ELEM_W bits: the store data.
REQ-015 The block SHALL have port dmem_ack, input, 1 bit: the access complete signal; dmem_rdata is valid with it.
REQ-016 The block SHALL have port dmem_rdata, input, LANES*ELEM_W bits: the load data.
REQ-017 The block SHALL have port halted, output, 1 bit: high in HALT.

Function
REQ-018 The instruction fields SHALL be: op=[31:26], rd=[25:21], rs1=[20:16], rs2=[15:11], imm=[15:8], addr/target=[ADDR_W-1:0]; register indices are taken modulo NREG.
REQ-019 The opcodes SHALL be: 00 NOP, 01 SADD, 02 SSUB, 03 SADDI (rs1+imm), 04 VADD, 05 VSUB, 06 VAND, 07 VOR, 10 SLD, 11 SST, 12 VLD, 13 VST, 20 BEQZ (if S[rs1]==0), 21 JMP, 3F HALT; any other opcode executes as NOP.
REQ-020 The FSM states SHALL be IDLE→FETCH→EXEC→{MEM}→WB→FETCH, plus HALT.
REQ-021 In FETCH, the block SHALL hold imem_req=1 with a stable imem_addr until imem_ack, then latch the instruction and go to EXEC.
REQ-022 In EXEC, the block SHALL compute the ALU result or the branch decision in one cycle; loads and stores go to MEM, HALT goes to HALT, and all others go to WB.
REQ-023 In MEM, the block SHALL hold dmem_req, dmem_we, dmem_addr and dmem_wdata stable until dmem_ack, then go to WB.
REQ-024 dmem_wdata for SST SHALL be S[rd] zero-extended; dmem_wdata for VST SHALL be V[rd].
REQ-025 In WB, the block SHALL write rd (the scalar file for S-ops/SLD, where SLD uses rdata[ELEM_W-1:0]; the vector file for V-ops/VLD) and update PC, then go to FETCH.
REQ-026 PC update SHALL be PC+1 by default, target for JMP or a taken BEQZ, with wrap modulo 2^ADDR_W.
REQ-027 The scalar and vector arithmetic SHALL wrap modulo 2^ELEM_W per lane, with no carry between lanes.
REQ-028 Register 0 of each file SHALL be writable (no hard-zero).
REQ-029 The latency SHALL be: ALU/branch = fetch wait + 3 cycles; load/store = fetch wait + data wait + 4 cycles.
REQ-030 An ack arriving in the same cycle as the request rises SHALL be accepted (zero-wait memory).
REQ-031 An ack while no request is outstanding SHALL be ignored.
REQ-032 HALT SHALL be terminal until reset; in HALT, req outputs are 0 and halted=1.
REQ-033 IDLE SHALL last exactly one cycle after reset deassertion, then go to FETCH.

Reset
REQ-034 When rst=0, the block SHALL asynchronously set: state=IDLE, PC=0, imem_req=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, halted=0, and all registers in both files=0.
REQ-035 Reset asserted mid-FETCH or mid-MEM SHALL drop the request immediately, and the aborted instruction SHALL cause no register write.

Structure
REQ-036 A shared package vcore_pkg SHALL hold the opcode constants, the FSM state enumeration and the field bit positions.
REQ-037 The lane-parallel ALU SHALL be one sub-module, vcore_lane_alu, parametrised by LANES and ELEM_W and purely combinational; it is shared by the scalar ops with LANES=1.

Verification
REQ-038 The bench SHALL cover: reset, then SADDI S1=S0+5, SADDI S2=S0+250, SADD S3=S1+S2 → S3=0xFF; SADDI S3+=1 → 0x00 (wrap).
REQ-039 The bench SHALL cover: VLD V1 with rdata 0x0102030405060708, VLD V2 with 0xFFFFFFFFFFFFFFFF, VADD V3 → VST emits 0x0001020304050607 (per-lane wrap).
REQ-040 The bench SHALL cover: dmem_ack delayed 5 cycles during VST → dmem_req, dmem_addr and dmem_wdata are stable for all 5 cycles and PC is unchanged until WB.
REQ-041 The bench SHALL cover: BEQZ S0 to 0x040 → next imem_addr=0x040; with S0=1, BEQZ → imem_addr=PC+1; JMP at PC=0xFFF to 0x000 confirms the address wrap.
REQ-042 The bench SHALL cover: rst pulled low while imem_req=1 and ack pending → imem_req=0 within the same cycle; after release, the first fetch is at PC=0.
REQ-043 The bench SHALL cover: HALT → halted=1, and no further requests for 20 cycles despite spurious acks.

Source files
------------

// File: rtl/vcore_pkg.sv
// Shared definitions for the multi-cycle vector core.
// Holds the opcode encodings, instruction field positions, the control FSM
// state enumeration, the lane ALU operation select, and small decode helpers
// that classify an opcode by the register file or memory path it uses.
package vcore_pkg;

  // Opcode encodings (instruction bits [31:26])
  localparam logic [5:0] OP_NOP   = 6'h00;
  localparam logic [5:0] OP_SADD  = 6'h01;
  localparam logic [5:0] OP_SSUB  = 6'h02;
  localparam logic [5:0] OP_SADDI = 6'h03;
  localparam logic [5:0] OP_VADD  = 6'h04;
  localparam logic [5:0] OP_VSUB  = 6'h05;
  localparam logic [5:0] OP_VAND  = 6'h06;
  localparam logic [5:0] OP_VOR   = 6'h07;
  localparam logic [5:0] OP_SLD   = 6'h10;
  localparam logic [5:0] OP_SST   = 6'h11;
  localparam logic [5:0] OP_VLD   = 6'h12;
  localparam logic [5:0] OP_VST   = 6'h13;
  localparam logic [5:0] OP_BEQZ  = 6'h20;
  localparam logic [5:0] OP_JMP   = 6'h21;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  // Instruction field positions (LSB of each field)
  localparam int OP_LSB  = 26;
  localparam int OP_W    = 6;
  localparam int RD_LSB  = 21;
  localparam int RS1_LSB = 16;
  localparam int RS2_LSB = 11;
  localparam int IMM_LSB = 8;
  localparam int IMM_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR
  } alu_op_e;

  // Opcodes that go through the MEM state
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_SLD) || (op == OP_SST) || (op == OP_VLD) || (op == OP_VST);
  endfunction

  function automatic logic is_store_op(input logic [5:0] op);
    return (op == OP_SST) || (op == OP_VST);
  endfunction

  // Opcodes whose result lands in the scalar file
  function automatic logic writes_scalar(input logic [5:0] op);
    return (op == OP_SADD) || (op == OP_SSUB) || (op == OP_SADDI) || (op == OP_SLD);
  endfunction

  // Opcodes whose result lands in the vector file
  function automatic logic writes_vector(input logic [5:0] op);
    return (op == OP_VADD) || (op == OP_VSUB) || (op == OP_VAND) ||
           (op == OP_VOR)  || (op == OP_VLD);
  endfunction

endpackage

// File: rtl/vcore_lane_alu.sv
// Lane-parallel combinational ALU.
// Ports:
//   op - operation select (add, sub, and, or)
//   a  - LANES packed operands of ELEM_W bits, lane 0 in the low bits
//   b  - second operand, same packing
//   y  - per-lane result, same packing
// Each lane wraps modulo 2^ELEM_W independently; no carry or borrow ever
// crosses a lane boundary. The scalar datapath reuses this with LANES=1.
module vcore_lane_alu
  import vcore_pkg::*;
#(
  parameter int LANES  = 8,
  parameter int ELEM_W = 8
) (
  input  alu_op_e                   op,
  input  logic [LANES*ELEM_W-1:0]   a,
  input  logic [LANES*ELEM_W-1:0]   b,
  output logic [LANES*ELEM_W-1:0]   y
);

  // Slicing every lane to ELEM_W bits before the operator is what keeps the
  // carry chains separated.
  always_comb begin
    y = '0;
    for (int i = 0; i < LANES; i++) begin
      case (op)
        ALU_ADD: y[i*ELEM_W +: ELEM_W] = a[i*ELEM_W +: ELEM_W] + b[i*ELEM_W +: ELEM_W];
        ALU_SUB: y[i*ELEM_W +: ELEM_W] = a[i*ELEM_W +: ELEM_W] - b[i*ELEM_W +: ELEM_W];
        ALU_AND: y[i*ELEM_W +: ELEM_W] = a[i*ELEM_W +: ELEM_W] & b[i*ELEM_W +: ELEM_W];
        default: y[i*ELEM_W +: ELEM_W] = a[i*ELEM_W +: ELEM_W] | b[i*ELEM_W +: ELEM_W];
      endcase
    end
  end

endmodule

// File: rtl/vector_core_mc.sv
// Multi-cycle scalar/vector core with request/acknowledge memory ports.
// Ports:
//   clk, rst            - rising-edge clock, asynchronous active-low reset
//   imem_req/addr       - instruction fetch request and PC
//   imem_ack/rdata      - fetch completion with the instruction word
//   dmem_req/we/addr    - data access request, store flag, address
//   dmem_wdata          - store data (scalar stores zero-extended)
//   dmem_ack/rdata      - data access completion with load data
//   halted              - high once a HALT has executed, until reset
// Sequence per instruction: FETCH -> EXEC -> (MEM) -> WB -> FETCH.
module vector_core_mc
  import vcore_pkg::*;
#(
  parameter int LANES  = 8,
  parameter int ELEM_W = 8,
  parameter int NREG   = 32,
  parameter int ADDR_W = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      imem_req,
  output logic [ADDR_W-1:0]         imem_addr,
  input  logic                      imem_ack,
  input  logic [31:0]               imem_rdata,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [ADDR_W-1:0]         dmem_addr,
  output logic [LANES*ELEM_W-1:0]   dmem_wdata,
  input  logic                      dmem_ack,
  input  logic [LANES*ELEM_W-1:0]   dmem_rdata,
  output logic                      halted
);

  localparam int VW    = LANES * ELEM_W;
  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      pc_q, pc_d;
  logic [31:0]            instr_q, instr_d;
  logic                   take_q, take_d;
  logic [ELEM_W-1:0]      wb_s_q, wb_s_d;
  logic [VW-1:0]          wb_v_q, wb_v_d;
  logic [ADDR_W-1:0]      dmem_addr_q, dmem_addr_d;
  logic [VW-1:0]          dmem_wdata_q, dmem_wdata_d;
  logic [ELEM_W-1:0]      sreg_q [NREG];
  logic [ELEM_W-1:0]      sreg_d [NREG];
  logic [VW-1:0]          vreg_q [NREG];
  logic [VW-1:0]          vreg_d [NREG];

  // Field decode of the latched instruction; register indices keep only the
  // low bits so they wrap modulo NREG.
  logic [OP_W-1:0]        op;
  logic [IDX_W-1:0]       rd_idx, rs1_idx, rs2_idx;
  logic [ADDR_W-1:0]      target;
  logic [ELEM_W-1:0]      imm_ext;

  assign op      = instr_q[OP_LSB +: OP_W];
  assign rd_idx  = instr_q[RD_LSB +: IDX_W];
  assign rs1_idx = instr_q[RS1_LSB +: IDX_W];
  assign rs2_idx = instr_q[RS2_LSB +: IDX_W];
  assign target  = instr_q[ADDR_W-1:0];
  assign imm_ext = ELEM_W'(instr_q[IMM_LSB +: IMM_W]);

  // Scalar and vector ALU operand/op selection
  alu_op_e           s_op, v_op;
  logic [ELEM_W-1:0] s_b, s_y;
  logic [VW-1:0]     v_y;

  always_comb begin
    s_op = (op == OP_SSUB) ? ALU_SUB : ALU_ADD;
    s_b  = (op == OP_SADDI) ? imm_ext : sreg_q[rs2_idx];
    case (op)
      OP_VSUB: v_op = ALU_SUB;
      OP_VAND: v_op = ALU_AND;
      OP_VOR:  v_op = ALU_OR;
      default: v_op = ALU_ADD;
    endcase
  end

  vcore_lane_alu #(.LANES(1), .ELEM_W(ELEM_W)) u_scalar_alu (
    .op (s_op),
    .a  (sreg_q[rs1_idx]),
    .b  (s_b),
    .y  (s_y)
  );

  vcore_lane_alu #(.LANES(LANES), .ELEM_W(ELEM_W)) u_vector_alu (
    .op (v_op),
    .a  (vreg_q[rs1_idx]),
    .b  (vreg_q[rs2_idx]),
    .y  (v_y)
  );

  // Next-state logic. EXEC captures the result (or load/store address and
  // data) so MEM and WB only ever read registered values, which keeps the
  // memory request fields stable while waiting for an acknowledge.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    take_d       = take_q;
    wb_s_d       = wb_s_q;
    wb_v_d       = wb_v_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    sreg_d       = sreg_q;
    vreg_d       = vreg_q;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        take_d = 1'b0;
        wb_s_d = s_y;
        wb_v_d = v_y;
        if (op == OP_JMP) begin
          take_d = 1'b1;
        end else if (op == OP_BEQZ) begin
          take_d = (sreg_q[rs1_idx] == '0);
        end
        if (op == OP_HALT) begin
          state_d = ST_HALT;
        end else if (is_mem_op(op)) begin
          dmem_addr_d  = target;
          dmem_wdata_d = (op == OP_VST) ? vreg_q[rd_idx] : VW'(sreg_q[rd_idx]);
          state_d      = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end

      ST_MEM: begin
        if (dmem_ack) begin
          wb_s_d  = dmem_rdata[ELEM_W-1:0];
          wb_v_d  = dmem_rdata;
          state_d = ST_WB;
        end
      end

      ST_WB: begin
        if (writes_scalar(op)) sreg_d[rd_idx] = wb_s_q;
        if (writes_vector(op)) vreg_d[rd_idx] = wb_v_q;
        pc_d    = take_q ? target : pc_q + ADDR_W'(1);
        state_d = ST_FETCH;
      end

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_IDLE;
    endcase
  end

  // State and register files; reset clears everything so an instruction
  // aborted mid-FETCH or mid-MEM never reaches WB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      instr_q      <= '0;
      take_q       <= 1'b0;
      wb_s_q       <= '0;
      wb_v_q       <= '0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        sreg_q[i] <= '0;
        vreg_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      take_q       <= take_d;
      wb_s_q       <= wb_s_d;
      wb_v_q       <= wb_v_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      sreg_q       <= sreg_d;
      vreg_q       <= vreg_d;
    end
  end

  // Requests decode straight from the state register, so an ack in the
  // first request cycle is accepted and reset drops them immediately.
  assign imem_req   = (state_q == ST_FETCH);
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == ST_MEM);
  assign dmem_we    = (state_q == ST_MEM) && is_store_op(op);
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_vector_core_mc.sv
// Directed bench for vector_core_mc: a small program in an instruction ROM
// exercises scalar wrap, per-lane vector wrap, a stalled vector store,
// branches and PC wrap, reset during a pending fetch, and HALT.
module tb_vector_core_mc;
  import vcore_pkg::*;

  localparam int LANES = 8, ELEM_W = 8, NREG = 32, ADDR_W = 12;
  localparam int VW = LANES * ELEM_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              imem_req, imem_ack;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              dmem_req, dmem_we, dmem_ack;
  logic [ADDR_W-1:0] dmem_addr;
  logic [VW-1:0]     dmem_wdata, dmem_rdata;
  logic              halted;

  vector_core_mc #(.LANES(LANES), .ELEM_W(ELEM_W), .NREG(NREG), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  logic [31:0] prog [0:4095];
  logic [63:0] dmem [0:4095];
  bit          imem_stall = 1'b0;
  bit          spurious   = 1'b0;
  int          dcnt;

  int errors = 0;
  int checks = 0;

  // Monitor state
  int                cyc = 0;
  bit                prev_ireq = 1'b0, prev_dreq = 1'b0;
  logic [ADDR_W-1:0] fetch_log [$];
  int                fetch_cyc [$];
  logic [ADDR_W-1:0] st_addr [$];
  logic [63:0]       st_data [$];
  logic [ADDR_W-1:0] st_pc [$];
  logic [ADDR_W-1:0] hold_addr, hold_pc;
  logic [63:0]       hold_data;
  int                hold_len = 0, max_hold = 0;

  // The one checking routine
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] encR(input logic [5:0] op, input int rd, input int rs1, input int rs2);
    return {op, 5'(rd), 5'(rs1), 5'(rs2), 11'b0};
  endfunction

  function automatic logic [31:0] encI(input logic [5:0] op, input int rd, input int rs1, input logic [7:0] imm);
    return {op, 5'(rd), 5'(rs1), imm, 8'b0};
  endfunction

  function automatic logic [31:0] encA(input logic [5:0] op, input int rd, input int rs1, input logic [11:0] a);
    return {op, 5'(rd), 5'(rs1), 4'b0, a};
  endfunction

  // Memory responder: zero-wait fetches, data ack delayed 5 cycles for 0x300
  initial begin
    imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0; dmem_rdata = '0; dcnt = 0;
    forever begin
      @(negedge clk);
      if (spurious) begin
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
      end else begin
        imem_ack   = imem_req && !imem_stall;
        imem_rdata = prog[imem_addr];
        dmem_rdata = dmem[dmem_addr];
        if (dmem_req) begin
          if (dcnt >= ((dmem_addr == 12'h300) ? 5 : 0)) begin
            dmem_ack = 1'b1;
            dcnt = 0;
          end else begin
            dmem_ack = 1'b0;
            dcnt++;
          end
        end else begin
          dmem_ack = 1'b0;
          dcnt = 0;
        end
      end
    end
  end

  // Advance one cycle, sample after the edge, log fetches/stores and check
  // that an outstanding data request holds its fields and the PC.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    cyc++;
    if (imem_req && !prev_ireq) begin
      fetch_log.push_back(imem_addr);
      fetch_cyc.push_back(cyc);
    end
    if (dmem_req && !prev_dreq) begin
      hold_addr = dmem_addr;
      hold_data = dmem_wdata;
      hold_pc   = imem_addr;
      hold_len  = 1;
      if (dmem_we) begin
        st_addr.push_back(dmem_addr);
        st_data.push_back(dmem_wdata);
        st_pc.push_back(imem_addr);
      end
    end else if (dmem_req) begin
      hold_len++;
      if (hold_len > max_hold) max_hold = hold_len;
      checkOutput("mem_addr_hold", 64'(dmem_addr), 64'(hold_addr));
      checkOutput("mem_wdata_hold", dmem_wdata, hold_data);
      checkOutput("mem_pc_hold", 64'(imem_addr), 64'(hold_pc));
    end
    prev_ireq = imem_req;
    prev_dreq = dmem_req;
  endtask

  task automatic runUntilFetches(input int n);
    int guard = 0;
    while (fetch_log.size() < n && guard < 500) begin
      applyStimulus();
      guard++;
    end
    checkOutput("fetch_count", 64'(fetch_log.size()), 64'(n));
  endtask

  logic [ADDR_W-1:0] exp_fetch [16];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      prog[i] = '0;
      dmem[i] = '0;
    end
    prog[0]      = encI(OP_SADDI, 1, 0, 8'd5);
    prog[1]      = encI(OP_SADDI, 2, 0, 8'd250);
    prog[2]      = encR(OP_SADD, 3, 1, 2);
    prog[3]      = encA(OP_SST, 3, 0, 12'h100);
    prog[4]      = encI(OP_SADDI, 3, 3, 8'd1);
    prog[5]      = encA(OP_SST, 3, 0, 12'h101);
    prog[6]      = encA(OP_VLD, 1, 0, 12'h200);
    prog[7]      = encA(OP_VLD, 2, 0, 12'h201);
    prog[8]      = encR(OP_VADD, 3, 1, 2);
    prog[9]      = encA(OP_VST, 3, 0, 12'h300);
    prog[10]     = encA(OP_BEQZ, 0, 0, 12'h040);
    prog['h040]  = encI(OP_SADDI, 0, 0, 8'd1);
    prog['h041]  = encA(OP_BEQZ, 0, 0, 12'h080);
    prog['h042]  = encA(OP_JMP, 0, 0, 12'hFFF);
    prog['hFFF]  = encA(OP_JMP, 0, 0, 12'h000);
    dmem['h200]  = 64'h0102030405060708;
    dmem['h201]  = 64'hFFFFFFFFFFFFFFFF;
    exp_fetch = '{12'h000, 12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006, 12'h007,
                  12'h008, 12'h009, 12'h00A, 12'h040, 12'h041, 12'h042, 12'hFFF, 12'h000};

    // Reset values
    rst = 1'b0;
    repeat (3) applyStimulus();
    checkOutput("rst_imem_req", 64'(imem_req), 64'd0);
    checkOutput("rst_dmem_req", 64'(dmem_req), 64'd0);
    checkOutput("rst_dmem_we", 64'(dmem_we), 64'd0);
    checkOutput("rst_halted", 64'(halted), 64'd0);
    checkOutput("rst_pc", 64'(imem_addr), 64'd0);
    checkOutput("rst_dmem_addr", 64'(dmem_addr), 64'd0);
    checkOutput("rst_dmem_wdata", dmem_wdata, 64'd0);

    // One IDLE cycle, then FETCH
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("idle_no_req", 64'(imem_req), 64'd0);
    applyStimulus();
    checkOutput("fetch_after_idle", 64'(imem_req), 64'd1);

    // Run the program up to the fetch that follows the wrap JMP
    runUntilFetches(16);
    imem_stall = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i < fetch_log.size()) checkOutput($sformatf("fetch_addr_%0d", i), 64'(fetch_log[i]), 64'(exp_fetch[i]));
    end
    if (fetch_cyc.size() >= 11) begin
      checkOutput("alu_latency", 64'(fetch_cyc[1] - fetch_cyc[0]), 64'd3);
      checkOutput("load_latency", 64'(fetch_cyc[7] - fetch_cyc[6]), 64'd4);
      checkOutput("vst_stall_latency", 64'(fetch_cyc[10] - fetch_cyc[9]), 64'd9);
    end
    checkOutput("store_count", 64'(st_addr.size()), 64'd3);
    if (st_addr.size() >= 3) begin
      checkOutput("sst_s3_addr", 64'(st_addr[0]), 64'h100);
      checkOutput("sst_s3_ff", st_data[0], 64'h00000000000000FF);
      checkOutput("sst_s3_wrap", st_data[1], 64'h0);
      checkOutput("vst_addr", 64'(st_addr[2]), 64'h300);
      checkOutput("vst_lane_wrap", st_data[2], 64'h0001020304050607);
      checkOutput("vst_pc", 64'(st_pc[2]), 64'h009);
    end
    checkOutput("vst_hold_cycles", 64'(max_hold), 64'd6);

    // Reset while a fetch is pending
    repeat (2) applyStimulus();
    checkOutput("stall_req", 64'(imem_req), 64'd1);
    checkOutput("stall_pc", 64'(imem_addr), 64'd0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst_drops_req", 64'(imem_req), 64'd0);
    prog[0] = encR(OP_HALT, 0, 0, 0);
    imem_stall = 1'b0;
    repeat (2) applyStimulus();
    fetch_log.delete();
    @(negedge clk);
    rst = 1'b1;
    runUntilFetches(1);
    if (fetch_log.size() >= 1) checkOutput("first_fetch_pc", 64'(fetch_log[0]), 64'd0);

    // HALT and spurious acks
    for (int g = 0; g < 10 && !halted; g++) applyStimulus();
    checkOutput("halted", 64'(halted), 64'd1);
    spurious = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus();
      checkOutput("halt_no_req", {62'b0, imem_req, dmem_req}, 64'd0);
    end
    checkOutput("halt_sticky", 64'(halted), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
